econet_rx_deframer: RTL

- Receive-side HDLC deframer for the Econet link, the counterpart of the transmit-side FCS generation.
- Takes the serial line bit-by-bit on econet_clk and detects opening and closing flags.
- Removes stuffed zeros, detects aborts, assembles LSB-first bytes and streams them out.
- Checks the CRC-16/CCITT residue at the closing flag and reports a good/bad frame status to the Econet frame buffer logic.

---
 rtl/econet_rx_deframer_pkg.sv | 31 +++
 rtl/econet_rx_deframer_if.sv | 28 ++
 rtl/econet_rx_deframer_bit_destuff.sv | 64 ++++++
 rtl/econet_rx_deframer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/econet_rx_deframer_pkg.sv
// Shared definitions for the Econet receive deframer.
//   FCSINIT / FCSGOOD : CRC-16/CCITT preset and the residue left by a good frame
//   FCS_POLY          : reflected CCITT polynomial (LSB-first arithmetic)
//   FLAG              : HDLC flag byte; its run of ones sets the stuff/flag/abort thresholds
//   rx_state_e        : frame FSM states
//   fcs_next_byte     : folds one received byte into the running CRC
package econet_pkg;

  localparam logic [15:0] FCSINIT  = 16'hFFFF;
  localparam logic [15:0] FCSGOOD  = 16'hF0B8;
  localparam logic [15:0] FCS_POLY = 16'h8408;
  localparam logic [7:0]  FLAG     = 8'h7E;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2
  } rx_state_e;

  // Bytewise CRC update; the byte enters LSB first, matching the line order.
  function automatic logic [15:0] fcs_next_byte(input logic [15:0] crc,
                                                input logic [7:0]  data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ FCS_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/econet_rx_deframer_if.sv
// Line-side input and byte-stream output bundle of the Econet receive deframer.
//   bit_en, rxd : one qualified line bit per bit_en cycle
//   rx_data, rx_valid, rx_sof : delivered byte stream
//   rx_eof, rx_fcs_ok, rx_abort, rx_active : frame status
// master = the deframer, slave = the line source / frame buffer side.
interface econet_rx_deframer_if;

  logic       bit_en;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_sof;
  logic       rx_eof;
  logic       rx_fcs_ok;
  logic       rx_abort;
  logic       rx_active;

  modport master (
    input  bit_en, rxd,
    output rx_data, rx_valid, rx_sof, rx_eof, rx_fcs_ok, rx_abort, rx_active
  );

  modport slave (
    output bit_en, rxd,
    input  rx_data, rx_valid, rx_sof, rx_eof, rx_fcs_ok, rx_abort, rx_active
  );

endinterface

// File: rtl/econet_rx_deframer_bit_destuff.sv
// Ones counter and line decoder for the Econet receiver.
//   econet_clk, reset : clock, asynchronous active-high reset
//   bit_en, rxd       : qualified line bit
//   bit_valid/bit_data: a bit for the byte assembler (stuffed zeros removed)
//   flag              : the zero that terminates a flag
//   abort             : the one that makes the run of ones reach seven
// Strobes are combinational from the current bit; the parent registers them.
module econet_bit_destuff
  import econet_pkg::*;
(
  input  logic econet_clk,
  input  logic reset,
  input  logic bit_en,
  input  logic rxd,
  output logic bit_valid,
  output logic bit_data,
  output logic flag,
  output logic abort
);

  localparam logic [2:0] FLAG_ONES  = 3'($countones(FLAG));
  localparam logic [2:0] STUFF_ONES = FLAG_ONES - 3'd1;
  localparam logic [2:0] ABORT_ONES = FLAG_ONES + 3'd1;

  logic [2:0] ones_q, ones_d;

  always_ff @(posedge econet_clk or posedge reset) begin
    if (reset) begin
      ones_q <= '0;
    end else begin
      ones_q <= ones_d;
    end
  end

  always_comb begin
    ones_d    = ones_q;
    bit_valid = 1'b0;
    bit_data  = rxd;
    flag      = 1'b0;
    abort     = 1'b0;
    if (bit_en) begin
      if (rxd) begin
        if (ones_q == FLAG_ONES) begin
          ones_d = ABORT_ONES;
          abort  = 1'b1;
        end else if (ones_q != ABORT_ONES) begin
          // The sixth one is passed on tentatively; a following zero
          // turns it into a flag, a following one into an abort.
          ones_d    = ones_q + 3'd1;
          bit_valid = 1'b1;
        end
        // Ones beyond an abort saturate silently (idle line).
      end else begin
        ones_d = '0;
        if (ones_q == FLAG_ONES) begin
          flag = 1'b1;
        end else if (ones_q != STUFF_ONES) begin
          bit_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/econet_rx_deframer.sv
// Econet receive-side HDLC deframer.
//   econet_clk : single clock, rising edge
//   reset      : asynchronous active-high reset; discards any partial frame
//   rx         : line input (bit_en, rxd) and byte/status outputs
//                (rx_data, rx_valid, rx_sof, rx_eof, rx_fcs_ok, rx_abort, rx_active)
// Bytes are assembled LSB first and folded into CRC-16/CCITT; at the closing
// flag the residue, byte count and byte alignment decide rx_fcs_ok.
// Every output is registered one clock after the causing bit.
module econet_rx_deframer
  import econet_pkg::*;
#(
  parameter int MIN_BYTES = 4,
  parameter int MAX_BYTES = 2048
) (
  input  logic econet_clk,
  input  logic reset,
  econet_rx_deframer_if.master rx
);

  localparam int              CNT_W = $clog2(MAX_BYTES + 2);
  localparam logic [CNT_W-1:0] MIN_B = CNT_W'(MIN_BYTES);
  localparam logic [CNT_W-1:0] MAX_B = CNT_W'(MAX_BYTES);

  logic bit_valid, bit_data, flag, abort;

  econet_bit_destuff u_destuff (
    .econet_clk (econet_clk),
    .reset      (reset),
    .bit_en     (rx.bit_en),
    .rxd        (rx.rxd),
    .bit_valid  (bit_valid),
    .bit_data   (bit_data),
    .flag       (flag),
    .abort      (abort)
  );

  rx_state_e        state_q,    state_d;
  logic [7:0]       shreg_q,    shreg_d;
  logic [2:0]       bit_cnt_q,  bit_cnt_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [15:0]      crc_q,      crc_d;
  logic [7:0]       rx_data_q,  rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_sof_q,   rx_sof_d;
  logic             rx_eof_q,   rx_eof_d;
  logic             rx_fcs_ok_q, rx_fcs_ok_d;
  logic             rx_abort_q, rx_abort_d;

  logic [7:0] byte_next;
  logic       frame_ok;
  logic       clear_frame;

  always_ff @(posedge econet_clk or posedge reset) begin
    if (reset) begin
      state_q     <= HUNT;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      crc_q       <= FCSINIT;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_sof_q    <= 1'b0;
      rx_eof_q    <= 1'b0;
      rx_fcs_ok_q <= 1'b0;
      rx_abort_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      crc_q       <= crc_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_sof_q    <= rx_sof_d;
      rx_eof_q    <= rx_eof_d;
      rx_fcs_ok_q <= rx_fcs_ok_d;
      rx_abort_q  <= rx_abort_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    crc_d       = crc_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_sof_d    = 1'b0;
    rx_eof_d    = 1'b0;
    rx_fcs_ok_d = 1'b0;
    rx_abort_d  = 1'b0;
    clear_frame = 1'b0;

    byte_next = {bit_data, shreg_q[7:1]};
    // An aligned frame has shifted exactly the flag's leading zero and six
    // ones past the last byte boundary when the flag completes.
    frame_ok  = (bit_cnt_q == 3'd7) && (crc_q == FCSGOOD) &&
                (byte_cnt_q >= MIN_B) && (byte_cnt_q <= MAX_B);

    unique case (state_q)
      HUNT: begin
        if (flag) begin
          state_d     = SYNC;
          clear_frame = 1'b1;
        end
      end

      SYNC: begin
        if (flag) begin
          clear_frame = 1'b1;
        end else if (abort) begin
          state_d     = HUNT;
          clear_frame = 1'b1;
        end else if (bit_valid) begin
          state_d   = DATA;
          shreg_d   = byte_next;
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end

      DATA: begin
        if (flag) begin
          // With no byte assembled the bits since the last flag were just
          // another flag (idle fill), so it closes nothing.
          if (byte_cnt_q != '0) begin
            rx_eof_d    = 1'b1;
            rx_fcs_ok_d = frame_ok;
          end
          state_d     = SYNC;
          clear_frame = 1'b1;
        end else if (abort) begin
          // Likewise an idle line right after a flag is not a frame abort.
          rx_abort_d  = (byte_cnt_q != '0);
          state_d     = HUNT;
          clear_frame = 1'b1;
        end else if (bit_valid) begin
          shreg_d = byte_next;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d  = '0;
            byte_cnt_d = byte_cnt_q + 1'b1;
            crc_d      = fcs_next_byte(crc_q, byte_next);
            if (byte_cnt_q == MAX_B) begin
              // Overrun: close the frame as bad and wait for a fresh flag.
              rx_eof_d    = 1'b1;
              state_d     = HUNT;
              clear_frame = 1'b1;
            end else begin
              rx_data_d  = byte_next;
              rx_valid_d = 1'b1;
              rx_sof_d   = (byte_cnt_q == '0);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end

      default: begin
        state_d     = HUNT;
        clear_frame = 1'b1;
      end
    endcase

    if (clear_frame) begin
      shreg_d    = '0;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      crc_d      = FCSINIT;
    end
  end

  assign rx.rx_data   = rx_data_q;
  assign rx.rx_valid  = rx_valid_q;
  assign rx.rx_sof    = rx_sof_q;
  assign rx.rx_eof    = rx_eof_q;
  assign rx.rx_fcs_ok = rx_fcs_ok_q;
  assign rx.rx_abort  = rx_abort_q;
  assign rx.rx_active = (state_q == DATA);

endmodule
